// File: rtl/i2s_capture.sv
// i2s_capture: I2S record-path receiver. BCLK/LRC/DAT are oversampled in the mclk domain and stereo pairs are presented on valid/ready.
// Optional macro I2S_CAPTURE_OVF_COUNT_EN adds rec_ovf_count, an 8-bit saturating count of dropped pairs.
module i2s_capture #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  input  logic                   audio_I2S_bclk,
  input  logic                   audio_I2S_reclrc,
  input  logic                   audio_I2S_recdat,
  output logic [SAMPLE_BITS-1:0] rec_left,
  output logic [SAMPLE_BITS-1:0] rec_right,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic                   rec_ovf,
`ifdef I2S_CAPTURE_OVF_COUNT_EN
  output logic [7:0]             rec_ovf_count,
`endif
  input  logic                   rec_ovf_clr
);

  localparam int IDX_W = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  logic                   r_bclk_s1, r_bclk_s2, r_bclk_prev;
  logic                   r_lrc_s1, r_lrc_s2, r_lrc_last;
  logic                   r_dat_s1, r_dat_s2;
  logic [SAMPLE_BITS-1:0] r_shreg;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [SAMPLE_BITS-1:0] r_left_hold;
  logic                   r_left_ok;
  state_t                 r_state;

  logic                   w_rise;
  logic                   w_change;
  logic [SAMPLE_BITS-1:0] w_shreg_cap;
  logic [IDX_W-1:0]       w_idx_cap;
  logic [SAMPLE_BITS-1:0] w_word;
  state_t                 w_state_nxt;
  logic                   w_left_load;
  logic                   w_pair_new;
  logic                   w_left_ok_nxt;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_drop;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_prev <= 1'b0;
      r_lrc_s1    <= 1'b0;
      r_lrc_s2    <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
    end else begin
      r_bclk_s1   <= audio_I2S_bclk;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_prev <= r_bclk_s2;
      r_lrc_s1    <= audio_I2S_reclrc;
      r_lrc_s2    <= r_lrc_s1;
      r_dat_s1    <= audio_I2S_recdat;
      r_dat_s2    <= r_dat_s1;
    end
  end

  assign w_rise   = r_bclk_s2 & ~r_bclk_prev;
  assign w_change = w_rise & (r_lrc_s2 != r_lrc_last);

  // The change-edge bit is the LSB of the ending word, so the commit uses the post-shift view.
  always_comb begin
    w_shreg_cap = r_shreg;
    w_idx_cap   = r_bit_idx;
    if (r_bit_idx < IDX_W'(SAMPLE_BITS)) begin
      w_shreg_cap = {r_shreg[SAMPLE_BITS-2:0], r_dat_s2};
      w_idx_cap   = r_bit_idx + IDX_W'(1);
    end
    w_word = w_shreg_cap << (IDX_W'(SAMPLE_BITS) - w_idx_cap);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_lrc_last <= 1'b0;
    end else if (w_rise) begin
      r_lrc_last <= r_lrc_s2;
      if (w_change) begin
        r_shreg   <= '0;
        r_bit_idx <= '0;
      end else begin
        r_shreg   <= w_shreg_cap;
        r_bit_idx <= w_idx_cap;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_left_load   = 1'b0;
    w_pair_new    = 1'b0;
    w_left_ok_nxt = r_left_ok;
    if (w_change) begin
      unique case (r_state)
        ST_SYNC: begin
          w_left_ok_nxt = 1'b0;
          w_state_nxt   = r_lrc_s2 ? ST_RIGHT : ST_LEFT;
        end
        ST_LEFT: begin
          if (r_lrc_s2) begin
            w_left_load   = 1'b1;
            w_left_ok_nxt = 1'b1;
            w_state_nxt   = ST_RIGHT;
          end else begin
            w_left_ok_nxt = 1'b0;
            w_state_nxt   = ST_SYNC;
          end
        end
        ST_RIGHT: begin
          w_left_ok_nxt = 1'b0;
          if (!r_lrc_s2) begin
            w_pair_new  = r_left_ok;
            w_state_nxt = ST_LEFT;
          end else begin
            w_state_nxt = ST_SYNC;
          end
        end
        default: begin
          w_left_ok_nxt = 1'b0;
          w_state_nxt   = ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SYNC;
      r_left_ok   <= 1'b0;
      r_left_hold <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_left_ok <= w_left_ok_nxt;
      if (w_left_load) begin
        r_left_hold <= w_word;
      end
    end
  end

  assign w_accept = rec_valid & rec_ready;
  assign w_load   = w_pair_new & (~rec_valid | rec_ready);
  assign w_drop   = w_pair_new & rec_valid & ~rec_ready;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rec_left  <= '0;
      rec_right <= '0;
      rec_valid <= 1'b0;
    end else if (w_load) begin
      rec_left  <= r_left_hold;
      rec_right <= w_word;
      rec_valid <= 1'b1;
    end else if (w_accept) begin
      rec_valid <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rec_ovf <= 1'b0;
    end else if (rec_ovf_clr) begin
      rec_ovf <= 1'b0;
    end else if (w_drop) begin
      rec_ovf <= 1'b1;
    end
  end

`ifdef I2S_CAPTURE_OVF_COUNT_EN
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rec_ovf_count <= '0;
    end else if (rec_ovf_clr) begin
      rec_ovf_count <= '0;
    end else if (w_drop && (rec_ovf_count != 8'hFF)) begin
      rec_ovf_count <= rec_ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_capture.sv
// tb_i2s_capture: randomized I2S stream stimulus checked against a slot-level reference model of the receiver.
`timescale 1ns/1ps
module tb_i2s_capture;
  localparam int SB = 16;

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk = 1'b0;
  logic          lrc = 1'b0;
  logic          dat = 1'b0;
  logic          rec_ready = 1'b0;
  logic          rec_ovf_clr = 1'b0;
  logic [SB-1:0] rec_left, rec_right;
  logic          rec_valid, rec_ovf;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
  logic [7:0]    rec_ovf_count;
`endif

  always #5 mclk = ~mclk;

  i2s_capture #(.SAMPLE_BITS(SB)) dut (
    .mclk             (mclk),
    .rst_n            (rst_n),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .rec_left         (rec_left),
    .rec_right        (rec_right),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .rec_ovf          (rec_ovf),
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    .rec_ovf_count    (rec_ovf_count),
`endif
    .rec_ovf_clr      (rec_ovf_clr)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int vrise_cyc = -1;
  logic mon_prev = 1'b0;
  logic [SB-1:0] obs_l[$], obs_r[$];
  logic [SB-1:0] exp_l[$], exp_r[$];
  bit s_lrc[$], s_dat[$];
  bit pend = 1'b0;
  bit clr_on_rise = 1'b0;

  // Record every handshake and the cycle at which rec_valid rises.
  initial forever begin
    @(posedge mclk);
    cyc++;
    #1;
    if (rec_valid === 1'b1 && mon_prev !== 1'b1) vrise_cyc = cyc;
    if (rec_valid === 1'b1 && rec_ready === 1'b1) begin
      obs_l.push_back(rec_left);
      obs_r.push_back(rec_right);
    end
    mon_prev = rec_valid;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // One BCLK period (8 mclk low, 8 high); LRC/DAT change with the falling edge.
  task automatic drive_rise(input bit l, input bit d);
    @(negedge mclk);
    bclk = 1'b0; lrc = l; dat = d;
    repeat (7) @(negedge mclk);
    @(negedge mclk);
    bclk = 1'b1;
    rise_cyc = cyc;
    s_lrc.push_back(l);
    s_dat.push_back(d);
    for (int j = 1; j <= 7; j++) begin
      @(negedge mclk);
      if (clr_on_rise) begin
        if (j == 2) rec_ovf_clr = 1'b1;
        if (j == 3) begin rec_ovf_clr = 1'b0; clr_on_rise = 1'b0; end
      end
    end
  endtask

  // Slot of n rises: previous word's LSB first, then w[n-1:1]; w[0] goes out at the next slot's first rise.
  task automatic send_slot(input bit l, input logic [31:0] w, input int n);
    drive_rise(l, pend);
    for (int k = n - 1; k >= 1; k--) drive_rise(l, w[k]);
    pend = w[0];
  endtask

  task automatic send_frame(input logic [31:0] wl, input logic [31:0] wr, input int n);
    send_slot(1'b0, wl, n);
    send_slot(1'b1, wr, n);
  endtask

  task automatic finish_stream();
    drive_rise(1'b0, pend);
    repeat (4) @(negedge mclk);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    bclk = 1'b0;
    repeat (2) @(negedge mclk);
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (4) @(negedge mclk);
    s_lrc.delete(); s_dat.delete();
    obs_l.delete(); obs_r.delete();
    vrise_cyc = -1;
  endtask

  // Reference: split the sampled stream into slots at LRC changes, take the first SB bits of each slot
  // (left-aligned, zero-padded), skip the first boundary, pair a left slot with the following right slot.
  task automatic build_expected();
    bit prev, synced, have_left, b;
    logic [SB-1:0] lw, word;
    int start, len;
    prev = 1'b0; synced = 1'b0; have_left = 1'b0; start = 0; lw = '0;
    exp_l.delete(); exp_r.delete();
    for (int i = 0; i < s_lrc.size(); i++) begin
      if (s_lrc[i] != prev) begin
        len = i - start + 1;
        word = '0;
        for (int k = 0; k < SB; k++) begin
          b = (k < len) ? s_dat[start + k] : 1'b0;
          word = {word[SB-2:0], b};
        end
        if (synced) begin
          if (prev == 1'b0) begin
            lw = word;
            have_left = 1'b1;
          end else begin
            if (have_left) begin
              exp_l.push_back(lw);
              exp_r.push_back(word);
            end
            have_left = 1'b0;
          end
        end
        synced = 1'b1;
        start = i + 1;
        prev = s_lrc[i];
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge mclk);
    n_total++; if (rec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rec_valid); else n_pass++;
    n_total++; if (rec_left !== '0) $display("FAIL reset_left: got %h want 0", rec_left); else n_pass++;
    n_total++; if (rec_right !== '0) $display("FAIL reset_right: got %h want 0", rec_right); else n_pass++;
    n_total++; if (rec_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", rec_ovf_count); else n_pass++;
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);
  endtask

  task automatic test_basic();
    do_reset();
    rec_ready = 1'b1;
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame(32'h0000_A5C3, 32'h0000_1234, 16);
    finish_stream();
    n_total++; if (obs_l.size() !== 1) $display("FAIL basic_count: got %0d pairs want 1", obs_l.size()); else n_pass++;
    n_total++; if (obs_l[0] !== 16'hA5C3) $display("FAIL basic_left: got %h want a5c3", obs_l[0]); else n_pass++;
    n_total++; if (obs_r[0] !== 16'h1234) $display("FAIL basic_right: got %h want 1234", obs_r[0]); else n_pass++;
    n_total++;
    if (vrise_cyc - rise_cyc !== 3) $display("FAIL basic_latency: got %0d mclk want 3", vrise_cyc - rise_cyc);
    else n_pass++;
  endtask

  task automatic test_startup();
    logic [15:0] l1, r1, l2, r2;
    l1 = 16'($urandom); r1 = 16'($urandom); l2 = 16'($urandom); r2 = 16'($urandom);
    do_reset();
    rec_ready = 1'b1;
    send_slot(1'b1, 32'($urandom), 7);
    send_frame({16'h0, l1}, {16'h0, r1}, 16);
    send_frame({16'h0, l2}, {16'h0, r2}, 16);
    finish_stream();
    build_expected();
    n_total++; if (obs_l.size() !== 2) $display("FAIL startup_count: got %0d pairs want 2", obs_l.size()); else n_pass++;
    n_total++;
    if (obs_l[0] !== l1 || obs_r[0] !== r1) $display("FAIL startup_first: got %h/%h want %h/%h", obs_l[0], obs_r[0], l1, r1);
    else n_pass++;
    n_total++;
    if (obs_l[1] !== exp_l[1] || obs_r[1] !== exp_r[1])
      $display("FAIL startup_second: got %h/%h want %h/%h", obs_l[1], obs_r[1], exp_l[1], exp_r[1]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    rec_ready = 1'b0;
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame(32'h1111, 32'h2222, 16);
    send_slot(1'b0, 32'h3333, 16);
    n_total++; if (rec_valid !== 1'b1) $display("FAIL bp_valid1: got %b want 1", rec_valid); else n_pass++;
    n_total++; if (rec_ovf !== 1'b0) $display("FAIL bp_ovf_early: got %b want 0", rec_ovf); else n_pass++;
    send_slot(1'b1, 32'h4444, 16);
    finish_stream();
    n_total++; if (rec_valid !== 1'b1) $display("FAIL bp_valid2: got %b want 1", rec_valid); else n_pass++;
    n_total++;
    if (rec_left !== 16'h1111 || rec_right !== 16'h2222) $display("FAIL bp_held: got %h/%h want 1111/2222", rec_left, rec_right);
    else n_pass++;
    n_total++; if (rec_ovf !== 1'b1) $display("FAIL bp_ovf: got %b want 1", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd1) $display("FAIL bp_count: got %0d want 1", rec_ovf_count); else n_pass++;
`endif
    rec_ovf_clr = 1'b1;
    @(negedge mclk);
    rec_ovf_clr = 1'b0;
    @(negedge mclk);
    n_total++; if (rec_ovf !== 1'b0) $display("FAIL bp_ovf_clr: got %b want 0", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd0) $display("FAIL bp_count_clr: got %0d want 0", rec_ovf_count); else n_pass++;
`endif
    n_total++; if (rec_valid !== 1'b1) $display("FAIL bp_valid_after_clr: got %b want 1", rec_valid); else n_pass++;
    rec_ready = 1'b1;
    repeat (2) @(negedge mclk);
    n_total++; if (rec_valid !== 1'b0) $display("FAIL bp_accept: got %b want 0", rec_valid); else n_pass++;
  endtask

  task automatic test_clr_priority();
    logic [15:0] p1;
    p1 = 16'($urandom);
    do_reset();
    rec_ready = 1'b0;
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame({16'h0, p1}, 32'($urandom), 16);
    send_frame(32'($urandom), 32'($urandom), 16);
    clr_on_rise = 1'b1;
    send_slot(1'b0, 32'($urandom), 16);
    n_total++; if (rec_ovf !== 1'b0) $display("FAIL prio_ovf: got %b want 0", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd0) $display("FAIL prio_count: got %0d want 0", rec_ovf_count); else n_pass++;
`endif
    n_total++; if (rec_left !== p1) $display("FAIL prio_held: got %h want %h", rec_left, p1); else n_pass++;
    send_slot(1'b1, 32'($urandom), 16);
    finish_stream();
    n_total++; if (rec_ovf !== 1'b1) $display("FAIL prio_ovf_later: got %b want 1", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd1) $display("FAIL prio_count_later: got %0d want 1", rec_ovf_count); else n_pass++;
`endif
  endtask

  task automatic test_long_slot();
    logic [31:0] wr;
    wr = $urandom;
    do_reset();
    rec_ready = 1'b1;
    send_frame($urandom, $urandom, 32);
    send_frame({16'hBEEF, 16'hFFFF}, wr, 32);
    finish_stream();
    n_total++; if (obs_l.size() !== 1) $display("FAIL long_count: got %0d pairs want 1", obs_l.size()); else n_pass++;
    n_total++; if (obs_l[0] !== 16'hBEEF) $display("FAIL long_left: got %h want beef", obs_l[0]); else n_pass++;
    n_total++; if (obs_r[0] !== wr[31:16]) $display("FAIL long_right: got %h want %h", obs_r[0], wr[31:16]); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] cl, cr;
    cl = 16'($urandom); cr = 16'($urandom);
    do_reset();
    rec_ready = 1'b0;
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame(32'($urandom), 32'($urandom), 16);
    send_slot(1'b0, 32'($urandom), 7);
    @(negedge mclk);
    bclk = 1'b0;
    repeat (2) @(posedge mclk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (rec_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", rec_valid); else n_pass++;
    n_total++; if (rec_left !== '0 || rec_right !== '0) $display("FAIL rstmid_data: got %h/%h want 0/0", rec_left, rec_right); else n_pass++;
    n_total++; if (rec_ovf !== 1'b0) $display("FAIL rstmid_ovf: got %b want 0", rec_ovf); else n_pass++;
`ifdef I2S_CAPTURE_OVF_COUNT_EN
    n_total++; if (rec_ovf_count !== 8'd0) $display("FAIL rstmid_count: got %0d want 0", rec_ovf_count); else n_pass++;
`endif
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    s_lrc.delete(); s_dat.delete(); obs_l.delete(); obs_r.delete();
    rec_ready = 1'b1;
    for (int k = 0; k < 9; k++) drive_rise(1'b0, 1'($urandom));
    send_slot(1'b1, 32'($urandom), 16);
    send_frame({16'h0, cl}, {16'h0, cr}, 16);
    finish_stream();
    n_total++; if (obs_l.size() !== 1) $display("FAIL rstmid_count_pairs: got %0d pairs want 1", obs_l.size()); else n_pass++;
    n_total++;
    if (obs_l[0] !== cl || obs_r[0] !== cr) $display("FAIL rstmid_pair: got %h/%h want %h/%h", obs_l[0], obs_r[0], cl, cr);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [15:0] f1l, f1r, f2l, f2r, f3l, f3r, f4l, f4r;
    logic [31:0] w;
    int hits, n;
    f1l = 16'($urandom); f1r = 16'($urandom); f2l = 16'($urandom); f2r = 16'($urandom) | 16'h0001;
    f3l = 16'($urandom); f3r = 16'($urandom); f4l = 16'($urandom); f4r = 16'($urandom);
    do_reset();
    rec_ready = 1'b1;
    send_frame(32'($urandom), 32'($urandom), 16);
    send_frame({16'h0, f1l}, {16'h0, f1r}, 16);
    send_slot(1'b0, {16'h0, f2l}, 16);
    w = {16'h0, f2r};
    drive_rise(1'b1, pend);
    for (int k = 15; k >= 1; k--) drive_rise((k == 8) ? 1'b0 : 1'b1, w[k]);
    pend = w[0];
    send_frame({16'h0, f3l}, {16'h0, f3r}, 16);
    send_frame({16'h0, f4l}, {16'h0, f4r}, 16);
    finish_stream();
    build_expected();
    n = obs_l.size();
    n_total++; if (n !== exp_l.size()) $display("FAIL glitch_count: got %0d pairs want %0d", n, exp_l.size()); else n_pass++;
    hits = 0;
    for (int i = 0; i < n && i < exp_l.size(); i++)
      if (obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) hits++;
    n_total++; if (hits !== 0) $display("FAIL glitch_model: got %0d differing pairs want 0", hits); else n_pass++;
    hits = 0;
    for (int i = 0; i < n; i++) if (obs_l[i] === f2l && obs_r[i] === f2r) hits++;
    n_total++; if (hits !== 0) $display("FAIL glitch_dropped: got %0d intact glitched pairs want 0", hits); else n_pass++;
    n_total++;
    if (n < 2 || obs_l[n-2] !== f3l || obs_r[n-2] !== f3r || obs_l[n-1] !== f4l || obs_r[n-1] !== f4r)
      $display("FAIL glitch_resync: got %0d pairs, last %h/%h want %h/%h", n, obs_l[n-1], obs_r[n-1], f4l, f4r);
    else n_pass++;
  endtask

  task automatic test_random_lengths();
    int bad;
    do_reset();
    rec_ready = 1'b1;
    for (int f = 0; f < 7; f++) begin
      send_slot(1'b0, $urandom, int'($urandom_range(10, 22)));
      send_slot(1'b1, $urandom, int'($urandom_range(10, 22)));
    end
    finish_stream();
    build_expected();
    n_total++; if (obs_l.size() !== exp_l.size()) $display("FAIL rand_count: got %0d pairs want %0d", obs_l.size(), exp_l.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++) begin
      if (obs_l[i] !== exp_l[i] || obs_r[i] !== exp_r[i]) begin
        if (bad == 0) $display("FAIL rand_pair%0d: got %h/%h want %h/%h", i, obs_l[i], obs_r[i], exp_l[i], exp_r[i]);
        bad++;
      end
    end
    n_total++; if (bad !== 0) $display("FAIL rand_pairs: got %0d differing pairs want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_startup();
    test_backpressure();
    test_clr_priority();
    test_long_slot();
    test_reset_midframe();
    test_glitch();
    test_random_lengths();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
